// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types for the regfile writeback arbiter.
// One writeback request is a destination register plus its 64-bit data.
package regfile_wb_arbiter_pkg;

  localparam int WB_NREQ  = 2;
  localparam int WB_DEPTH = 2;

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// Per-requester writeback FIFO.
// Occupancy is tracked by count; full/empty derive from it only.
module wb_fifo
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  logic    pop,
  input  wb_req_t din,
  output logic    full,
  output logic    empty,
  output wb_req_t head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  wb_req_t        mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  // A full FIFO refuses the push even if it pops this cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin share of the regfile write port among writeback units,
// with a busy scoreboard for the issue stage's hazard check.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NREQ  = WB_NREQ,
  parameter int DEPTH = WB_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ-1:0][4:0]   req_rd,
  input  logic [NREQ-1:0][63:0]  req_data,
  output logic                   wd_en,
  output logic [4:0]             wd,
  output logic [63:0]            wd_data,
  input  logic                   issue_valid,
  input  logic [4:0]             issue_rd,
  output logic [31:0]            busy,
  output logic                   idle
);

  localparam int PW = (NREQ > 2) ? 2 : 1;

  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   rr_nxt;
  logic [PW-1:0]   win;
  logic [PW-1:0]   idx;
  logic [NREQ-1:0] full;
  logic [NREQ-1:0] empty;
  logic [NREQ-1:0] pop;
  wb_req_t         din  [NREQ];
  wb_req_t         head [NREQ];
  wb_req_t         gnt_req;
  logic            gnt;
  logic [31:0]     busy_nxt;

  for (genvar i = 0; i < NREQ; i++) begin : g_fifo
    assign din[i]       = '{rd: req_rd[i], data: req_data[i]};
    assign req_ready[i] = ~full[i];
    assign pop[i]       = gnt && (win == PW'(i));

    wb_fifo #(
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (req_valid[i]),
      .pop   (pop[i]),
      .din   (din[i]),
      .full  (full[i]),
      .empty (empty[i]),
      .head  (head[i])
    );
  end

  always_comb begin
    gnt = 1'b0;
    win = rr_ptr;
    idx = rr_ptr;
    for (int k = 0; k < NREQ; k++) begin
      idx = PW'((int'(rr_ptr) + k) % NREQ);
      if (!gnt && !empty[idx]) begin
        gnt = 1'b1;
        win = idx;
      end
    end
    gnt_req = head[win];
    rr_nxt  = PW'((int'(win) + 1) % NREQ);
  end

  // A same-cycle issue to the granted rd re-arms the bit: set wins.
  always_comb begin
    busy_nxt = busy;
    if (gnt) busy_nxt[gnt_req.rd] = 1'b0;
    if (issue_valid && issue_rd != 5'd0) busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr  <= '0;
      wd_en   <= 1'b0;
      wd      <= '0;
      wd_data <= '0;
      busy    <= '0;
    end else begin
      if (gnt) begin
        rr_ptr  <= rr_nxt;
        wd_en   <= (gnt_req.rd != 5'd0);
        wd      <= gnt_req.rd;
        wd_data <= gnt_req.data;
      end else begin
        wd_en   <= 1'b0;
      end
      busy <= busy_nxt;
    end
  end

  assign idle = (&empty) & ~wd_en;

  a_one_pending : assert property (
    @(posedge clk) disable iff (rst)
    (issue_valid && issue_rd != 5'd0) |->
    (!busy[issue_rd] || (gnt && gnt_req.rd == issue_rd))
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter.
// A negedge-written regfile model observes the write port.
module tb_regfile_wb_arbiter;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][4:0]  req_rd;
  logic [1:0][63:0] req_data;
  logic             wd_en;
  logic [4:0]       wd;
  logic [63:0]      wd_data;
  logic             issue_valid;
  logic [4:0]       issue_rd;
  logic [31:0]      busy;
  logic             idle;

  logic [63:0] regs [32];
  int n_cmp = 0;
  int n_bad = 0;

  regfile_wb_arbiter #(.NREQ(2), .DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_rd      (req_rd),
    .req_data    (req_data),
    .wd_en       (wd_en),
    .wd          (wd),
    .wd_data     (wd_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .busy        (busy),
    .idle        (idle)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wd_en) regs[wd] <= wd_data;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    tick;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #2;
    n_cmp++; if (wd_en !== 1'b0) begin n_bad++; $display("FAIL reset_wd_en: got %b want 0", wd_en); end
    n_cmp++; if (wd !== 5'd0) begin n_bad++; $display("FAIL reset_wd: got %0d want 0", wd); end
    n_cmp++; if (wd_data !== 64'd0) begin n_bad++; $display("FAIL reset_wd_data: got %0h want 0", wd_data); end
    n_cmp++; if (busy !== 32'd0) begin n_bad++; $display("FAIL reset_busy: got %0h want 0", busy); end
    n_cmp++; if (req_ready !== 2'b11) begin n_bad++; $display("FAIL reset_ready: got %b want 11", req_ready); end
    n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL reset_idle: got %b want 1", idle); end
    tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_single;
    issue_valid = 1'b1; issue_rd = 5'd5;
    tick;
    issue_valid = 1'b0;
    n_cmp++; if (busy[5] !== 1'b1) begin n_bad++; $display("FAIL single_busy_set: got %b want 1", busy[5]); end
    req_valid = 2'b01; req_rd[0] = 5'd5; req_data[0] = 64'hDEAD;
    tick;
    req_valid = 2'b00;
    n_cmp++; if (wd_en !== 1'b0) begin n_bad++; $display("FAIL single_no_bypass: got %b want 0", wd_en); end
    n_cmp++; if (idle !== 1'b0) begin n_bad++; $display("FAIL single_not_idle: got %b want 0", idle); end
    tick;
    n_cmp++; if (wd_en !== 1'b1) begin n_bad++; $display("FAIL single_wd_en: got %b want 1", wd_en); end
    n_cmp++; if (wd !== 5'd5) begin n_bad++; $display("FAIL single_wd: got %0d want 5", wd); end
    n_cmp++; if (wd_data !== 64'hDEAD) begin n_bad++; $display("FAIL single_wd_data: got %0h want dead", wd_data); end
    n_cmp++; if (busy[5] !== 1'b0) begin n_bad++; $display("FAIL single_busy_clr: got %b want 0", busy[5]); end
    @(negedge clk);
    #1;
    n_cmp++; if (regs[5] !== 64'hDEAD) begin n_bad++; $display("FAIL single_regfile: got %0h want dead", regs[5]); end
    tick;
    n_cmp++; if (wd_en !== 1'b0) begin n_bad++; $display("FAIL single_wd_en_drop: got %b want 0", wd_en); end
    n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL single_idle: got %b want 1", idle); end
  endtask

  task automatic test_contention;
    logic [4:0] exp_rd;
    int w;
    do_reset;
    req_valid = 2'b11;
    req_rd[0] = 5'd1; req_data[0] = 64'hA0;
    req_rd[1] = 5'd2; req_data[1] = 64'hB0;
    tick;
    for (int n = 0; n < 4; n++) begin
      tick;
      exp_rd = (n % 2 == 0) ? 5'd1 : 5'd2;
      n_cmp++; if (wd_en !== 1'b1 || wd !== exp_rd) begin
        n_bad++; $display("FAIL contention_grant%0d: got en=%b rd=%0d want en=1 rd=%0d", n, wd_en, wd, exp_rd);
      end
    end
    req_valid = 2'b00;
    w = 0;
    while (idle !== 1'b1 && w < 20) begin tick; w++; end
    n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL contention_drain: got idle=%b want 1", idle); end
  endtask

  task automatic test_backpressure;
    do_reset;
    req_valid = 2'b11;
    req_rd[0] = 5'd3; req_data[0] = 64'h30;
    req_rd[1] = 5'd4; req_data[1] = 64'h41;
    tick;
    req_valid = 2'b10;
    n_cmp++; if (req_ready !== 2'b11) begin n_bad++; $display("FAIL bp_ready_e1: got %b want 11", req_ready); end
    req_data[1] = 64'h42;
    tick;
    n_cmp++; if (wd !== 5'd3 || wd_data !== 64'h30) begin n_bad++; $display("FAIL bp_grant0: got rd=%0d d=%0h want rd=3 d=30", wd, wd_data); end
    n_cmp++; if (req_ready[1] !== 1'b0) begin n_bad++; $display("FAIL bp_full: got %b want 0", req_ready[1]); end
    req_data[1] = 64'h43;
    tick;
    n_cmp++; if (wd !== 5'd4 || wd_data !== 64'h41) begin n_bad++; $display("FAIL bp_grant1a: got rd=%0d d=%0h want rd=4 d=41", wd, wd_data); end
    n_cmp++; if (req_ready[1] !== 1'b1) begin n_bad++; $display("FAIL bp_reready: got %b want 1", req_ready[1]); end
    tick;
    req_valid = 2'b00;
    n_cmp++; if (wd_en !== 1'b1 || wd_data !== 64'h42) begin n_bad++; $display("FAIL bp_grant1b: got en=%b d=%0h want en=1 d=42", wd_en, wd_data); end
    tick;
    n_cmp++; if (wd_en !== 1'b1 || wd_data !== 64'h43) begin n_bad++; $display("FAIL bp_grant1c: got en=%b d=%0h want en=1 d=43", wd_en, wd_data); end
    tick;
    n_cmp++; if (wd_en !== 1'b0 || idle !== 1'b1) begin n_bad++; $display("FAIL bp_no_dup: got en=%b idle=%b want en=0 idle=1", wd_en, idle); end
  endtask

  task automatic test_x0;
    issue_valid = 1'b1; issue_rd = 5'd12;
    tick;
    issue_valid = 1'b0;
    req_valid = 2'b01; req_rd[0] = 5'd0; req_data[0] = 64'h1;
    tick;
    req_valid = 2'b00;
    n_cmp++; if (idle !== 1'b0) begin n_bad++; $display("FAIL x0_queued: got idle=%b want 0", idle); end
    tick;
    n_cmp++; if (wd_en !== 1'b0) begin n_bad++; $display("FAIL x0_wd_en: got %b want 0", wd_en); end
    n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL x0_popped: got idle=%b want 1", idle); end
    n_cmp++; if (busy !== 32'h0000_1000) begin n_bad++; $display("FAIL x0_busy: got %0h want 1000", busy); end
    @(negedge clk);
    #1;
    n_cmp++; if (regs[0] !== 64'd0) begin n_bad++; $display("FAIL x0_regfile: got %0h want 0", regs[0]); end
  endtask

  task automatic test_race;
    tick;
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick;
    issue_valid = 1'b0;
    n_cmp++; if (busy[7] !== 1'b1) begin n_bad++; $display("FAIL race_busy_set: got %b want 1", busy[7]); end
    req_valid = 2'b01; req_rd[0] = 5'd7; req_data[0] = 64'h77;
    tick;
    req_valid = 2'b00;
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick;
    issue_valid = 1'b0;
    n_cmp++; if (wd_en !== 1'b1 || wd !== 5'd7) begin n_bad++; $display("FAIL race_grant: got en=%b rd=%0d want en=1 rd=7", wd_en, wd); end
    n_cmp++; if (busy[7] !== 1'b1) begin n_bad++; $display("FAIL race_set_wins: got %b want 1", busy[7]); end
    req_valid = 2'b01; req_data[0] = 64'h78;
    tick;
    req_valid = 2'b00;
    tick;
    n_cmp++; if (wd_en !== 1'b1 || wd_data !== 64'h78) begin n_bad++; $display("FAIL race_second: got en=%b d=%0h want en=1 d=78", wd_en, wd_data); end
    n_cmp++; if (busy !== 32'h0000_1000) begin n_bad++; $display("FAIL race_busy_clr: got %0h want 1000", busy); end
    tick;
  endtask

  task automatic test_reset_midop;
    issue_valid = 1'b1; issue_rd = 5'd9;
    tick;
    issue_valid = 1'b0;
    req_valid = 2'b11;
    req_rd[0] = 5'd10; req_data[0] = 64'hC0;
    req_rd[1] = 5'd11; req_data[1] = 64'hD0;
    tick;
    tick;
    tick;
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (wd_en !== 1'b0) begin n_bad++; $display("FAIL midrst_wd_en: got %b want 0", wd_en); end
    n_cmp++; if (wd !== 5'd0 || wd_data !== 64'd0) begin n_bad++; $display("FAIL midrst_wd: got rd=%0d d=%0h want 0 0", wd, wd_data); end
    n_cmp++; if (busy !== 32'd0) begin n_bad++; $display("FAIL midrst_busy: got %0h want 0", busy); end
    n_cmp++; if (req_ready !== 2'b11) begin n_bad++; $display("FAIL midrst_ready: got %b want 11", req_ready); end
    n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL midrst_idle: got %b want 1", idle); end
    req_valid = 2'b00;
    rst = 1'b0;
    for (int n = 0; n < 5; n++) begin
      tick;
      n_cmp++; if (wd_en !== 1'b0 || idle !== 1'b1) begin
        n_bad++; $display("FAIL midrst_quiet%0d: got en=%b idle=%b want en=0 idle=1", n, wd_en, idle);
      end
    end
  endtask

  initial begin
    for (int r = 0; r < 32; r++) regs[r] = 64'd0;
    req_valid = 2'b00;
    req_rd = '0;
    req_data = '0;
    issue_valid = 1'b0;
    issue_rd = 5'd0;
    #1;
    test_reset;
    test_single;
    test_contention;
    test_backpressure;
    test_x0;
    test_race;
    test_reset_midop;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
